// File: rtl/gate_test_sequencer.sv
// Exhaustive 256-vector sequencer for a quad 2-input gate.
// Drives A/B, waits a settle time, checks Y, and logs failures.
module gate_test_sequencer #(
  parameter int SETTLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       abort,
  input  logic [2:0] func,
  output logic [3:0] a,
  output logic [3:0] b,
  input  logic [3:0] y,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [8:0] err_count,
  output logic [7:0] fail_vec,
  output logic       fail_valid
);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    SAMPLE,
    DONE
  } state_t;

  localparam logic [7:0] LAST = 8'(SETTLE_CYCLES - 1);

  state_t     st_q, st_d;
  logic [7:0] vec_q, vec_d;
  logic [7:0] cnt_q, cnt_d;
  logic [8:0] err_q, err_d;
  logic [7:0] fv_q, fv_d;
  logic       fval_q, fval_d;
  logic [2:0] func_q, func_d;
  logic [3:0] a_q, a_d;
  logic [3:0] b_q, b_d;
  logic [3:0] exp_y;
  logic       miss;
  logic [7:0] nxt;

  // Even vector bits feed A, odd bits feed B.
  function automatic logic [3:0] lane_a(input logic [7:0] v);
    return {v[6], v[4], v[2], v[0]};
  endfunction

  function automatic logic [3:0] lane_b(input logic [7:0] v);
    return {v[7], v[5], v[3], v[1]};
  endfunction

  // Expected gate response for the latched function.
  always_comb begin
    exp_y = a_q | b_q;
    unique case (func_q)
      3'd1:    exp_y = a_q & b_q;
      3'd2:    exp_y = ~(a_q & b_q);
      3'd3:    exp_y = ~(a_q | b_q);
      3'd4:    exp_y = a_q ^ b_q;
      default: exp_y = a_q | b_q;
    endcase
  end

  assign miss = (y != exp_y);
  assign nxt  = vec_q + 8'd1;

  // Next-state and datapath update.
  always_comb begin
    st_d   = st_q;
    vec_d  = vec_q;
    cnt_d  = cnt_q;
    err_d  = err_q;
    fv_d   = fv_q;
    fval_d = fval_q;
    func_d = func_q;
    a_d    = a_q;
    b_d    = b_q;
    unique case (st_q)
      IDLE, DONE: begin
        if (start) begin
          st_d   = SETTLE;
          vec_d  = 8'd0;
          cnt_d  = 8'd0;
          err_d  = 9'd0;
          fv_d   = 8'd0;
          fval_d = 1'b0;
          func_d = func;
          a_d    = 4'd0;
          b_d    = 4'd0;
        end else if (abort && st_q == DONE) begin
          st_d = IDLE;
          a_d  = 4'd0;
          b_d  = 4'd0;
        end
      end
      SETTLE: begin
        if (abort) begin
          st_d = IDLE;
          a_d  = 4'd0;
          b_d  = 4'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_q == LAST) st_d = SAMPLE;
        end
      end
      SAMPLE: begin
        if (abort) begin
          st_d = IDLE;
          a_d  = 4'd0;
          b_d  = 4'd0;
        end else begin
          if (miss) begin
            err_d = err_q + 9'd1;
            if (!fval_q) begin
              fv_d   = vec_q;
              fval_d = 1'b1;
            end
          end
          if (vec_q != 8'hff) begin
            vec_d = nxt;
            a_d   = lane_a(nxt);
            b_d   = lane_b(nxt);
            cnt_d = 8'd0;
            st_d  = SETTLE;
          end else begin
            st_d = DONE;
          end
        end
      end
      default: st_d = IDLE;
    endcase
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      st_q   <= IDLE;
      vec_q  <= 8'd0;
      cnt_q  <= 8'd0;
      err_q  <= 9'd0;
      fv_q   <= 8'd0;
      fval_q <= 1'b0;
      func_q <= 3'd0;
      a_q    <= 4'd0;
      b_q    <= 4'd0;
    end else begin
      st_q   <= st_d;
      vec_q  <= vec_d;
      cnt_q  <= cnt_d;
      err_q  <= err_d;
      fv_q   <= fv_d;
      fval_q <= fval_d;
      func_q <= func_d;
      a_q    <= a_d;
      b_q    <= b_d;
    end
  end

  assign a          = a_q;
  assign b          = b_q;
  assign busy       = (st_q == SETTLE) || (st_q == SAMPLE);
  assign done       = (st_q == DONE);
  assign pass       = done && (err_q == 9'd0);
  assign err_count  = err_q;
  assign fail_vec   = fv_q;
  assign fail_valid = fval_q;

endmodule

// File: tb/tb_gate_test_sequencer.sv
// Bench for gate_test_sequencer.
// Full runs from a table plus abort/reset/settle corner cases.
module tb_gate_test_sequencer;

  logic       clk = 1'b0;
  logic       reset, start, start2, abort, stuck;
  logic [2:0] func;
  logic [3:0] a, b, y;
  logic       busy, done, pass, fval;
  logic [8:0] err;
  logic [7:0] fv;

  logic [3:0] a1, b1, a3, b3;
  logic [3:0] d1a, d2a, d1b, d2b;
  logic       busy1, done1, pass1, fval1;
  logic       busy3, done3, pass3, fval3;
  logic [8:0] err1, err3;
  logic [7:0] fv1, fv3;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  assign y = stuck ? ((a | b) & 4'b0111) : (a | b);

  always @(posedge clk) begin
    d1a <= a1 | b1;
    d2a <= d1a;
    d1b <= a3 | b3;
    d2b <= d1b;
  end

  gate_test_sequencer #(.SETTLE_CYCLES(4)) u4 (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .func(func), .a(a), .b(b), .y(y), .busy(busy),
    .done(done), .pass(pass), .err_count(err),
    .fail_vec(fv), .fail_valid(fval)
  );

  gate_test_sequencer #(.SETTLE_CYCLES(1)) u1 (
    .clk(clk), .reset(reset), .start(start2), .abort(abort),
    .func(func), .a(a1), .b(b1), .y(d2a), .busy(busy1),
    .done(done1), .pass(pass1), .err_count(err1),
    .fail_vec(fv1), .fail_valid(fval1)
  );

  gate_test_sequencer #(.SETTLE_CYCLES(3)) u3 (
    .clk(clk), .reset(reset), .start(start2), .abort(abort),
    .func(func), .a(a3), .b(b3), .y(d2b), .busy(busy3),
    .done(done3), .pass(pass3), .err_count(err3),
    .fail_vec(fv3), .fail_valid(fval3)
  );

  typedef struct {
    logic [2:0] func;
    logic [2:0] func_after;
    logic       stuck;
    logic [8:0] err;
    logic [7:0] fv;
    logic       fval;
    logic       pass;
  } run_t;

  run_t tbl [8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  task automatic run(input bit poke, input logic [2:0] fa,
                     output int cyc);
    start = 1'b1;
    tick();
    start = 1'b0;
    func  = fa;
    cyc   = 0;
    while (busy && cyc < 3000) begin
      start = poke && (cyc == 100 || cyc == 700);
      tick();
      cyc++;
    end
    start = 1'b0;
  endtask

  task automatic wait_ab(input logic [3:0] ea, input logic [3:0] eb,
                         input string n);
    int k;
    k = 0;
    while (!(a === ea && b === eb) && k < 2000) begin
      tick();
      k++;
    end
    chk(n, 32'(a === ea && b === eb), 1);
  endtask

  task automatic chk_zero(input string n);
    chk({n, "_busy"}, 32'(busy), 0);
    chk({n, "_done"}, 32'(done), 0);
    chk({n, "_pass"}, 32'(pass), 0);
    chk({n, "_err"}, 32'(err), 0);
    chk({n, "_fv"}, 32'(fv), 0);
    chk({n, "_fval"}, 32'(fval), 0);
    chk({n, "_a"}, 32'(a), 0);
    chk({n, "_b"}, 32'(b), 0);
  endtask

  initial begin
    int cyc;
    int k;
    tbl[0] = '{3'd0, 3'd0, 1'b0, 9'd0,   8'h00, 1'b0, 1'b1};
    tbl[1] = '{3'd0, 3'd1, 1'b0, 9'd0,   8'h00, 1'b0, 1'b1};
    tbl[2] = '{3'd0, 3'd0, 1'b1, 9'd192, 8'h40, 1'b1, 1'b0};
    tbl[3] = '{3'd1, 3'd1, 1'b0, 9'd240, 8'h01, 1'b1, 1'b0};
    tbl[4] = '{3'd5, 3'd2, 1'b0, 9'd0,   8'h00, 1'b0, 1'b1};
    tbl[5] = '{3'd4, 3'd4, 1'b0, 9'd175, 8'h03, 1'b1, 1'b0};
    tbl[6] = '{3'd2, 3'd2, 1'b0, 9'd240, 8'h00, 1'b1, 1'b0};
    tbl[7] = '{3'd3, 3'd3, 1'b0, 9'd256, 8'h00, 1'b1, 1'b0};

    reset = 1'b1; start = 1'b0; start2 = 1'b0;
    abort = 1'b0; func = 3'd0; stuck = 1'b0;
    repeat (3) tick();
    chk_zero("reset");
    reset = 1'b0;
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("idle_abort_busy", 32'(busy), 0);
    chk("idle_abort_done", 32'(done), 0);

    for (int i = 0; i < 8; i++) begin
      func  = tbl[i].func;
      stuck = tbl[i].stuck;
      run(1'b0, tbl[i].func_after, cyc);
      chk($sformatf("t%0d_cycles", i), cyc, 1280);
      chk($sformatf("t%0d_done", i), 32'(done), 1);
      chk($sformatf("t%0d_pass", i), 32'(pass), 32'(tbl[i].pass));
      chk($sformatf("t%0d_err", i), 32'(err), 32'(tbl[i].err));
      chk($sformatf("t%0d_fv", i), 32'(fv), 32'(tbl[i].fv));
      chk($sformatf("t%0d_fval", i), 32'(fval), 32'(tbl[i].fval));
    end

    func = 3'd0; stuck = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_ab(4'b0100, 4'b0000, "reach_10");
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort10_busy", 32'(busy), 0);
    chk("abort10_a", 32'(a), 0);
    chk("abort10_b", 32'(b), 0);
    chk("abort10_done", 32'(done), 0);
    tick();
    chk("abort10_idle", 32'(busy), 0);
    run(1'b0, 3'd0, cyc);
    chk("rerun_cycles", cyc, 1280);
    chk("rerun_pass", 32'(pass), 1);

    stuck = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_ab(4'b0000, 4'b1000, "reach_80a");
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort80_busy", 32'(busy), 0);
    chk("abort80_err", 32'(err), 64);
    chk("abort80_fv", 32'(fv), 32'h40);
    chk("abort80_fval", 32'(fval), 1);

    start = 1'b1;
    tick();
    start = 1'b0;
    wait_ab(4'b0000, 4'b1000, "reach_80r");
    chk("pre_reset_err", 32'(err), 64);
    reset = 1'b1; start = 1'b1; abort = 1'b1;
    tick();
    reset = 1'b0; start = 1'b0; abort = 1'b0;
    chk_zero("midreset");

    stuck = 1'b0;
    run(1'b1, 3'd0, cyc);
    chk("poke_cycles", cyc, 1280);
    chk("poke_pass", 32'(pass), 1);

    start = 1'b1; abort = 1'b1;
    tick();
    chk("done_start_wins", 32'(busy), 1);
    tick();
    start = 1'b0; abort = 1'b0;
    chk("busy_abort_wins", 32'(busy), 0);
    chk("busy_abort_done", 32'(done), 0);
    run(1'b0, 3'd0, cyc);
    chk("e_done", 32'(done), 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("done_abort_done", 32'(done), 0);
    chk("done_abort_busy", 32'(busy), 0);

    func = 3'd0;
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    k = 0;
    while (!(done1 && done3) && k < 3000) begin
      tick();
      k++;
    end
    chk("s1_done", 32'(done1), 1);
    chk("s3_done", 32'(done3), 1);
    chk("s1_pass", 32'(pass1), 0);
    chk("s3_pass", 32'(pass3), 1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/gate_test_sequencer.md
GATE_TEST_SEQUENCER -- requirements
Module: gate_test_sequencer

Interface
REQ-001 Parameter SETTLE_CYCLES, default 4, number of clk cycles each vector is held before sampling; legal range 1..255.
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  begin a test run; sampled in IDLE or DONE only.
REQ-005 abort  input  1  terminate the current run.
REQ-006 func  input  3  expected gate function: 0 OR, 1 AND, 2 NAND, 3 NOR, 4 XOR, 5-7 treated as OR.
REQ-007 a  output  4  registered gate input A, a[i] drives gate i+1.
REQ-008 b  output  4  registered gate input B, b[i] drives gate i+1.
REQ-009 y  input  4  gate outputs returned from the quad 2-input gate under test.
REQ-010 busy  output  1  high in SETTLE and SAMPLE.
REQ-011 done  output  1  high while in DONE.
REQ-012 pass  output  1  valid when done=1; high iff err_count==0.
REQ-013 err_count  output  9  number of failing vectors in the current or last run (0..256).
REQ-014 fail_vec  output  8  index of the first failing vector.
REQ-015 fail_valid  output  1  high once fail_vec holds a captured value.

Function
REQ-016 States SHALL be IDLE, SETTLE, SAMPLE, DONE; one-hot or binary encoding is free.
REQ-017 Vector index vec is 8 bits; a[i]=vec[2i], b[i]=vec[2i+1] for i=0..3.
REQ-018 On start=1 in IDLE or DONE: vec<=0, a/b<=vector 0, settle_cnt<=0, err_count<=0, fail_valid<=0, fail_vec<=0, func latched, next state SETTLE.
REQ-019 func changes after the start cycle SHALL have no effect on the run.
REQ-020 SETTLE: settle_cnt increments each cycle; when settle_cnt==SETTLE_CYCLES-1, next state SAMPLE.
REQ-021 SAMPLE: expected[i] = latched function of (a[i], b[i]); a mismatch on any bit of y counts as one failing vector.
REQ-022 On a failing vector, err_count increments by 1; if fail_valid==0, fail_vec<=vec and fail_valid<=1 in the same cycle.
REQ-023 SAMPLE with vec!=255: vec<=vec+1, a/b updated to the new vector, settle_cnt<=0, next state SETTLE.
REQ-024 SAMPLE with vec==255: next state DONE; vec does not wrap; a/b hold their last value.
REQ-025 Each vector occupies exactly SETTLE_CYCLES+1 cycles; DONE is entered 256*(SETTLE_CYCLES+1) cycles after the start cycle.
REQ-026 start while busy=1 SHALL be ignored.
REQ-027 abort=1 in SETTLE or SAMPLE: next state IDLE, a=b=0 next cycle, no error counted for that cycle; err_count, fail_vec and fail_valid retained.
REQ-028 abort and start asserted together: abort wins when busy; in IDLE or DONE, start wins.
REQ-029 DONE: done=1, pass=(err_count==0); held until start (restart) or abort/reset (to IDLE).
REQ-030 abort in IDLE SHALL have no effect.

Reset
REQ-031 reset=1 at any clock edge, including mid-run, SHALL force state IDLE, a=0, b=0, busy=0, done=0, pass=0, err_count=0, fail_vec=0, fail_valid=0, vec=0, settle_cnt=0.
REQ-032 reset SHALL take priority over start and abort.

Verification
REQ-033 Ideal OR model (y=a|b), func=0, SETTLE_CYCLES=4, pulse start -> busy high for 1280 cycles, then done=1, pass=1, err_count=0, fail_valid=0.
REQ-034 OR model with y[3] stuck at 0, func=0 -> done, pass=0, err_count=192, fail_vec=0x40, fail_valid=1.
REQ-035 Ideal OR model, func=1 (AND) -> err_count=240, fail_vec=0x01, pass=0.
REQ-036 Ideal OR model, abort asserted at vector 0x10 -> busy=0 and a=b=0 the next cycle, state IDLE, done=0; a subsequent start completes with pass=1.
REQ-037 reset asserted mid-run at vector 0x80 with a stuck-at fault active -> all outputs at reset values the next cycle; start pulses during busy are ignored (the run length is unchanged).
REQ-038 SETTLE_CYCLES=1, with a model of 2 clk cycles of output delay -> pass=0 (sampling occurs before the gate settles); the same model with SETTLE_CYCLES=3 -> pass=1.
